// File: rtl/clk_switch_pkg.sv
// clk_switch_pkg: shared state encoding and mux select constants for the clock switch controller
package clk_switch_pkg;
  typedef enum logic [2:0] {LINKDN, IDLE, DEBOUNCE, QUIESCE, SWITCH, RELEASE} state_t;
  localparam logic SEL_MII  = 1'b0;
  localparam logic SEL_GMII = 1'b1;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: width-parameterised two-flop synchroniser for asynchronous level inputs
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] m;
  // two-stage capture into the clk domain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= '0;
    else {q, m} <= {m, d};
endmodule

// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: debounces PHY speed/link and sequences glitch-free RX/TX clock source changes
module clk_switch_ctrl
  import clk_switch_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 1000,
  parameter int   QUIESCE_CYCLES  = 16,
  parameter int   SETTLE_CYCLES   = 64,
  parameter logic INIT_SEL        = SEL_MII,
  parameter int   CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic phy_speed_1000,
  input  logic phy_link_up,
  output logic clk_sel,
  output logic dp_rst_n,
  output logic busy,
  output logic switch_done
);
  logic spd_s, lnk_s, tgt, from_idle;
  logic [CNT_W-1:0] cnt;
  state_t state;
  sync_2ff #(.W(2)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({phy_link_up, phy_speed_1000}),
    .q     ({lnk_s, spd_s})
  );
  // sequencer: every output is registered and updated on the transition into a state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= LINKDN;
      cnt         <= '0;
      tgt         <= INIT_SEL;
      from_idle   <= 1'b0;
      clk_sel     <= INIT_SEL;
      dp_rst_n    <= 1'b0;
      busy        <= 1'b0;
      switch_done <= 1'b0;
    end else begin
      switch_done <= 1'b0;
      cnt         <= cnt + CNT_W'(1);
      case (state)
        LINKDN:
          if (lnk_s) begin
            tgt       <= spd_s;
            from_idle <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= DEBOUNCE;
          end
        IDLE:
          if (!lnk_s) begin
            dp_rst_n <= 1'b0;
            cnt      <= '0;
            state    <= LINKDN;
          end else if (spd_s != clk_sel) begin
            tgt       <= spd_s;
            from_idle <= 1'b1;
            cnt       <= '0;
            busy      <= 1'b1;
            state     <= DEBOUNCE;
          end
        DEBOUNCE:
          if (spd_s != tgt || !lnk_s) begin
            cnt      <= '0;
            busy     <= 1'b0;
            dp_rst_n <= from_idle && lnk_s;
            state    <= (from_idle && lnk_s) ? IDLE : LINKDN;
          end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            cnt      <= '0;
            dp_rst_n <= 1'b0;
            state    <= QUIESCE;
          end
        QUIESCE:
          if (cnt == CNT_W'(QUIESCE_CYCLES - 1)) begin
            cnt     <= '0;
            clk_sel <= tgt;
            state   <= SWITCH;
          end
        SWITCH:
          if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
            cnt         <= '0;
            busy        <= 1'b0;
            dp_rst_n    <= lnk_s;
            switch_done <= lnk_s;
            state       <= lnk_s ? RELEASE : LINKDN;
          end
        RELEASE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= LINKDN;
        end
      endcase
    end
endmodule

// File: tb/tb_clk_switch_ctrl.sv
// tb_clk_switch_ctrl: random PHY status stimulus scored against an event-level reference model
module tb_clk_switch_ctrl;
  localparam int   DB = 4;
  localparam int   QC = 2;
  localparam int   SC = 3;
  localparam logic INIT = 1'b0;
  localparam int   N  = 3000;
  localparam int   NA = N + 64;
  typedef struct {int cyc; int kind; logic val;} ev_t;
  logic clk = 0, rst_n = 0, speed = 0, link = 0;
  logic clk_sel, dp_rst_n, busy, switch_done;
  logic in_l[NA], in_p[NA], sl[NA], sp[NA];
  ev_t exp_q[$];
  int vectors = 0, miscompares = 0, cyc = 0;
  bit running = 0;
  logic pdp, psel, pbusy;

  clk_switch_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .QUIESCE_CYCLES  (QC),
    .SETTLE_CYCLES   (SC),
    .INIT_SEL        (INIT),
    .CNT_W           (16)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .phy_speed_1000 (speed),
    .phy_link_up    (link),
    .clk_sel        (clk_sel),
    .dp_rst_n       (dp_rst_n),
    .busy           (busy),
    .switch_done    (switch_done)
  );

  always #5 clk = ~clk;

  task automatic push(input int c, input int k, input logic v);
    ev_t e;
    e.cyc = c; e.kind = k; e.val = v;
    if (c < N) exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  // Walks the synchronised input history, jumping whole phases with arithmetic.
  // Event kinds: 0 dp_rst_n change, 1 clk_sel change, 2 busy change, 3 switch_done pulse.
  task automatic build_model();
    int t = 0, e, ab, q, r;
    logic sel = INIT, tgt, fi, idle = 0;
    while (t < N) begin
      if (!idle && !sl[t]) begin t++; continue; end
      if (idle && !sl[t]) begin push(t + 1, 0, 1'b0); idle = 0; t++; continue; end
      if (idle && sp[t] == sel) begin t++; continue; end
      fi = idle;
      tgt = sp[t];
      e = t + 1;
      push(e, 2, 1'b1);
      ab = -1;
      for (int k = e; k < e + DB; k++)
        if (ab < 0 && (!sl[k] || sp[k] != tgt)) ab = k;
      if (ab >= 0) begin
        if (fi && !sl[ab]) push(ab + 1, 0, 1'b0);
        push(ab + 1, 2, 1'b0);
        idle = fi && sl[ab];
        t = ab + 1;
        continue;
      end
      q = e + DB;
      if (fi) push(q, 0, 1'b0);
      if (tgt != sel) push(q + QC, 1, tgt);
      sel = tgt;
      r = q + QC + SC;
      if (sl[r - 1]) begin
        push(r, 0, 1'b1); push(r, 2, 1'b0); push(r, 3, 1'b1);
        idle = 1; t = r + 1;
      end else begin
        push(r, 2, 1'b0);
        idle = 0; t = r;
      end
    end
  endtask

  task automatic observe(input int kind, input logic val);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected event: kind=%0d val=%b at cycle %0d, none required", kind, val, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.cyc != cyc || e.kind != kind || e.val !== val) begin
        miscompares++;
        $display("FAIL event: got kind=%0d val=%b cycle=%0d, required kind=%0d val=%b cycle=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  // monitor: reports each output change to the scoreboard in a fixed per-cycle order
  always @(negedge clk) if (running) begin
    if (dp_rst_n !== pdp) observe(0, dp_rst_n);
    if (clk_sel !== psel) observe(1, clk_sel);
    if (busy !== pbusy) observe(2, busy);
    if (switch_done === 1'b1) observe(3, 1'b1);
    pdp = dp_rst_n; psel = clk_sel; pbusy = busy;
  end

  initial begin
    int t = 0, d;
    logic lv, pv;
    while (t < NA) begin
      lv = ($urandom_range(0, 9) != 0);
      pv = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(6, 30);
      for (int k = 0; k < d; k++)
        if (t + k < NA) begin in_l[t + k] = lv; in_p[t + k] = pv; end
      t += d;
    end
    for (int k = 0; k < NA; k++) begin
      sl[k] = (k >= 2) ? in_l[k - 2] : 1'b0;
      sp[k] = (k >= 2) ? in_p[k - 2] : 1'b0;
    end
    build_model();
    pdp = 1'b0; psel = INIT; pbusy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset clk_sel", clk_sel, INIT);
    check("reset dp_rst_n", dp_rst_n, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset switch_done", switch_done, 1'b0);
    rst_n = 1;
    for (int k = 0; k < N; k++) begin
      @(posedge clk); #1;
      cyc = k; running = 1;
      link = in_l[k]; speed = in_p[k];
    end
    @(posedge clk); #1;
    running = 0;
    while (exp_q.size() != 0) begin
      ev_t e = exp_q.pop_front();
      vectors++; miscompares++;
      $display("FAIL missing event: kind=%0d val=%b required at cycle %0d, never seen", e.kind, e.val, e.cyc);
    end
    rst_n = 0; link = 0; speed = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    link = 1; speed = 1;
    repeat (10) @(posedge clk);
    #2;
    check("mid-switch clk_sel", clk_sel, 1'b1);
    check("mid-switch busy", busy, 1'b1);
    check("mid-switch dp_rst_n", dp_rst_n, 1'b0);
    rst_n = 0;
    #1;
    check("async reset clk_sel", clk_sel, INIT);
    check("async reset dp_rst_n", dp_rst_n, 1'b0);
    check("async reset busy", busy, 1'b0);
    check("async reset switch_done", switch_done, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/clk_switch_ctrl.md
Name: clk_switch_ctrl

Overview:
- Sequences glitch-free Ethernet RX/TX clock-source changes (125 MHz GMII vs 25/2.5 MHz MII) through the global clock mux in the UDP path.
- Synchronises and debounces PHY speed/link status, holds the UDP datapath in reset around each switch, drives the mux select, then releases the datapath once the new clock has settled.
- Runs on the free-running system clock, never on the muxed clock.

Parameters:
- DEBOUNCE_CYCLES, 1000: cycles the synchronised status must stay unchanged before acting; >=1.
- QUIESCE_CYCLES, 16: cycles datapath reset is held before the select changes; >=1.
- SETTLE_CYCLES, 64: cycles after the select change before reset is released; >=1.
- INIT_SEL, 1'b0: clk_sel reset value (0 = i0/MII clock, 1 = i1/GMII clock).
- CNT_W, 16: shared counter width; must hold the maximum of the three cycle parameters.

Ports:
- clk input 1: free-running system clock.
- rst_n input 1: asynchronous active-low reset.
- phy_speed_1000 input 1: PHY reports 1000 Mb/s; asynchronous.
- phy_link_up input 1: PHY link status; asynchronous.
- clk_sel output 1: drives mux select s.
- dp_rst_n output 1: active-low reset to the UDP datapath.
- busy output 1: switch sequence in progress.
- switch_done output 1: one-cycle pulse when the datapath is released.

Behaviour:
- Reset
  - Reset is asynchronous, active-low: one clock; all flops clear on rst_n low.
  - Reset values: clk_sel=INIT_SEL, dp_rst_n=0, busy=0, switch_done=0, state=LINKDN, counter=0, synchronisers=0.
- Synchronisers
  - phy_speed_1000 and phy_link_up each pass through a 2-flop synchroniser; spd_s and lnk_s are the outputs.
  - An input change is visible on spd_s/lnk_s 2 cycles later.
- Outputs
  - All outputs are registered and change in the first cycle of the new state.
- States
  - LINKDN: dp_rst_n=0, busy=0. When lnk_s=1, latch tgt=spd_s, clear the counter, go to DEBOUNCE.
  - IDLE: dp_rst_n=1, busy=0.
    - If lnk_s=0, go to LINKDN; dp_rst_n=0 the next cycle.
    - Else if spd_s!=clk_sel, latch tgt=spd_s and go to DEBOUNCE.
  - DEBOUNCE: busy=1; dp_rst_n unchanged, so it stays 1 when entered from IDLE.
    - Counter increments each cycle.
    - If spd_s!=tgt, or lnk_s=0: from-IDLE entry returns to IDLE (or LINKDN when lnk_s=0); from-LINKDN entry returns to LINKDN.
    - After DEBOUNCE_CYCLES cycles in this state, go to QUIESCE.
  - QUIESCE: dp_rst_n=0, busy=1. Stays QUIESCE_CYCLES cycles, then goes to SWITCH.
  - SWITCH: clk_sel<=tgt in the entry cycle. Stays SETTLE_CYCLES cycles, then goes to RELEASE. The select change occurs even when tgt equals clk_sel (the path from LINKDN).
  - RELEASE: one cycle. dp_rst_n=1, busy=0, switch_done=1, then go to IDLE.
    - If lnk_s=0 on the final SWITCH cycle, go to LINKDN instead: dp_rst_n stays 0, no switch_done.
- Boundary rules
  - Inputs changing during QUIESCE/SWITCH are ignored; tgt is frozen.
  - A link drop during QUIESCE/SWITCH does not abort the switch; clk_sel is never left mid-change.
  - Counter clears on every state entry.
  - clk_sel changes at most once per sequence, only in SWITCH, and only while dp_rst_n=0.
- Reset mid-sequence returns immediately to reset values, including clk_sel=INIT_SEL. The downstream mux handles the asynchronous select change glitch-free.

Decomposition:
- Shared package clk_switch_pkg holds:
  - the state encoding (LINKDN, IDLE, DEBOUNCE, QUIESCE, SWITCH, RELEASE);
  - constants SEL_MII=1'b0 and SEL_GMII=1'b1.
- One natural sub-module: sync_2ff, a width-parameterised 2-flop synchroniser instanced once for {phy_link_up, phy_speed_1000}.
- FSM and counter stay in the top.

Test Plan (DEBOUNCE=4, QUIESCE=2, SETTLE=3, INIT_SEL=0):
- Reset release with link=0: dp_rst_n=0, clk_sel=0, busy=0. Link=1 and speed=1 at cycle 0 -> DEBOUNCE cycles 3-6, QUIESCE 7-8, clk_sel=1 at 9, dp_rst_n=1 and switch_done=1 at cycle 12 only.
- In IDLE with clk_sel=1, speed falls to 0 at cycle 0 -> dp_rst_n=0 at 7, clk_sel=0 at 9, dp_rst_n=1 and done at 12.
- Speed glitch of 2 cycles while IDLE -> DEBOUNCE entered then abandoned; clk_sel, dp_rst_n and switch_done unchanged.
- Speed toggles during SWITCH -> ignored; clk_sel keeps the latched tgt, and a new sequence starts only after the return to IDLE.
- Link drops during QUIESCE -> SWITCH completes, state goes to LINKDN, dp_rst_n stays 0, no switch_done pulse.
- rst_n asserted mid-SWITCH -> outputs take reset values asynchronously in the same cycle: clk_sel=0, dp_rst_n=0.
